// File: rtl/wb_m_pkg_hdl.sv
// Shared types for the Wishbone classic-cycle command engine:
// response status codes and the engine state encoding.
package wb_m_pkg_hdl;

   typedef enum logic [1:0] {
      WB_M_OK      = 2'd0,
      WB_M_ERR     = 2'd1,
      WB_M_TIMEOUT = 2'd2
   } wb_m_status_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_m_eng_state_e;

endpackage

// File: rtl/wb_m_cmd_engine.sv
// Wishbone B3 classic-cycle master: one bus cycle per accepted command,
// terminated by ack, err or timeout, answered with a tagged response.
module wb_m_cmd_engine
   import wb_m_pkg_hdl::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output wb_m_status_e            rsp_status,
   output logic                    cyc_o,
   output logic                    stb_o,
   output logic                    we_o,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic [DATA_WIDTH/8-1:0] sel_o,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic                    ack_i,
   input  logic                    err_i,
   output logic                    busy
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   wb_m_eng_state_e       r_state,       w_state_next;
   logic [CNT_WIDTH-1:0]  r_cnt,         w_cnt_next;
   logic                  r_cmd_ready,   w_cmd_ready_next;
   logic                  r_busy,        w_busy_next;
   logic                  r_cyc,         w_cyc_next;
   logic                  r_we,          w_we_next;
   logic [ADDR_WIDTH-1:0] r_adr,         w_adr_next;
   logic [DATA_WIDTH-1:0] r_dat,         w_dat_next;
   logic [SEL_WIDTH-1:0]  r_sel,         w_sel_next;
   logic                  r_rsp_valid,   w_rsp_valid_next;
   logic [DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata_next;
   wb_m_status_e          r_rsp_status,  w_rsp_status_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_cmd_ready  <= 1'b1;
         r_busy       <= 1'b0;
         r_cyc        <= 1'b0;
         r_we         <= 1'b0;
         r_adr        <= '0;
         r_dat        <= '0;
         r_sel        <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= '0;
         r_rsp_status <= WB_M_OK;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_cmd_ready  <= w_cmd_ready_next;
         r_busy       <= w_busy_next;
         r_cyc        <= w_cyc_next;
         r_we         <= w_we_next;
         r_adr        <= w_adr_next;
         r_dat        <= w_dat_next;
         r_sel        <= w_sel_next;
         r_rsp_valid  <= w_rsp_valid_next;
         r_rsp_rdata  <= w_rsp_rdata_next;
         r_rsp_status <= w_rsp_status_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_cmd_ready_next  = r_cmd_ready;
      w_busy_next       = r_busy;
      w_cyc_next        = r_cyc;
      w_we_next         = r_we;
      w_adr_next        = r_adr;
      w_dat_next        = r_dat;
      w_sel_next        = r_sel;
      w_rsp_valid_next  = r_rsp_valid;
      w_rsp_rdata_next  = r_rsp_rdata;
      w_rsp_status_next = r_rsp_status;

      case (r_state)
         IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_state_next     = BUS;
               w_cnt_next       = '0;
               w_cmd_ready_next = 1'b0;
               w_busy_next      = 1'b1;
               w_cyc_next       = 1'b1;
               w_we_next        = cmd_we;
               w_adr_next       = cmd_addr;
               w_dat_next       = cmd_we ? cmd_wdata : '0;
               w_sel_next       = cmd_sel;
            end
         end
         BUS: begin
            // err outranks ack, and either outranks a timeout in the same cycle
            if (err_i || ack_i || (r_cnt == CNT_LAST)) begin
               w_state_next     = RESP;
               w_cyc_next       = 1'b0;
               w_rsp_valid_next = 1'b1;
               w_rsp_rdata_next = '0;
               if (err_i) begin
                  w_rsp_status_next = WB_M_ERR;
               end else if (ack_i) begin
                  w_rsp_status_next = WB_M_OK;
                  w_rsp_rdata_next  = r_we ? '0 : dat_i;
               end else begin
                  w_rsp_status_next = WB_M_TIMEOUT;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_next     = IDLE;
               w_rsp_valid_next = 1'b0;
               w_cmd_ready_next = 1'b1;
               w_busy_next      = 1'b0;
            end
         end
         default: begin
            w_state_next     = IDLE;
            w_cmd_ready_next = 1'b1;
            w_busy_next      = 1'b0;
            w_cyc_next       = 1'b0;
            w_rsp_valid_next = 1'b0;
         end
      endcase
   end

   assign cmd_ready  = r_cmd_ready;
   assign busy       = r_busy;
   assign cyc_o      = r_cyc;
   assign stb_o      = r_cyc;
   assign we_o       = r_we;
   assign adr_o      = r_adr;
   assign dat_o      = r_dat;
   assign sel_o      = r_sel;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_status = r_rsp_status;

endmodule

// File: tb/tb_wb_m_cmd_engine.sv
// Directed bench for wb_m_cmd_engine: a transaction-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_wb_m_cmd_engine;
   import wb_m_pkg_hdl::*;

   localparam int AW = 32;
   localparam int DW = 16;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_i, cmd_valid, cmd_we, rsp_ready, ack_i, err_i;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata, dat_i;
   logic [SW-1:0] cmd_sel;
   logic          cmd_ready, rsp_valid, cyc_o, stb_o, we_o, busy;
   logic [DW-1:0] rsp_rdata, dat_o;
   logic [1:0]    rsp_status;
   logic [AW-1:0] adr_o;
   logic [SW-1:0] sel_o;

   always #5 clk = ~clk;

   wb_m_cmd_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
      .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i),
      .err_i(err_i), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction, either on the bus or awaiting pickup.
   bit            m_init = 1'b0;
   bit            m_fresh, m_on_bus, m_has_rsp;
   int            m_bus_cycles;
   logic          m_we;
   logic [AW-1:0] m_adr;
   logic [DW-1:0] m_dat;
   logic [SW-1:0] m_sel;
   logic [DW-1:0] m_rdata;
   logic [1:0]    m_status;

   task automatic model_finish(input logic [1:0] st, input logic [DW-1:0] rd);
      m_on_bus  = 1'b0;
      m_has_rsp = 1'b1;
      m_status  = st;
      m_rdata   = rd;
   endtask

   always @(posedge clk) begin
      if (rst_i) begin
         m_init = 1'b1; m_fresh = 1'b1; m_on_bus = 1'b0; m_has_rsp = 1'b0;
         m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
         m_rdata = '0; m_status = 2'd0; m_bus_cycles = 0;
      end else if (m_init) begin
         if (m_has_rsp) begin
            if (rsp_ready) m_has_rsp = 1'b0;
         end else if (m_on_bus) begin
            m_bus_cycles = m_bus_cycles + 1;
            if (err_i)                   model_finish(2'd1, '0);
            else if (ack_i)              model_finish(2'd0, m_we ? '0 : dat_i);
            else if (m_bus_cycles == TO) model_finish(2'd2, '0);
         end else if (cmd_valid) begin
            m_fresh = 1'b0; m_on_bus = 1'b1; m_bus_cycles = 0;
            m_we = cmd_we; m_adr = cmd_addr; m_sel = cmd_sel;
            m_dat = cmd_we ? cmd_wdata : '0;
         end
      end
   end

   typedef struct {
      logic [1:0]    st;
      logic [DW-1:0] rd;
      int            t;
   } obs_t;
   obs_t obs_q[$];
   int   cyc_no  = 0;
   int   stb_cnt = 0;

   always @(negedge clk) begin
      if (m_init) begin
         check("cmd_ready", cmd_ready, !m_on_bus && !m_has_rsp);
         check("busy", busy, m_on_bus || m_has_rsp);
         check("cyc_o", cyc_o, m_on_bus);
         check("stb_o", stb_o, m_on_bus);
         check("rsp_valid", rsp_valid, m_has_rsp);
         if (m_on_bus || m_fresh) begin
            check("we_o", we_o, m_we);
            check("adr_o", adr_o, m_adr);
            check("dat_o", dat_o, m_dat);
            check("sel_o", sel_o, m_sel);
         end
         if (m_has_rsp || m_fresh) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_status", rsp_status, m_status);
         end
         if (stb_o) stb_cnt++;
         if (rsp_valid && rsp_ready && !rst_i) begin
            obs_q.push_back('{st: rsp_status, rd: rsp_rdata, t: cyc_no});
            $display("rsp #%0d: status=%0d rdata=0x%04h cycle=%0d", obs_q.size(), rsp_status, rsp_rdata, cyc_no);
         end
         cyc_no++;
      end
   end

   task automatic send(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] sel);
      int n = 0;
      cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) check("cmd_accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      $display("cmd: we=%0b addr=0x%0h wdata=0x%04h sel=%b", we, addr, wdata, sel);
   endtask

   task automatic wait_rsp(input string name, output obs_t o);
      int n = 0;
      while (obs_q.size() == 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (obs_q.size() == 0) begin
         check({name, "_rsp_timeout"}, 0, 1);
         o = '{st: 2'd3, rd: '0, t: 0};
      end else begin
         o = obs_q.pop_front();
      end
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o, prev;
      int   n0;
      rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_sel = '0; rsp_ready = 1'b1;
      ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_cyc", cyc_o, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      cycle();

      // 1: zero-wait write
      stb_cnt = 0;
      send(1'b1, 32'h10, 16'hBEEF, 2'b11);
      ack_i = 1'b1; cycle(); ack_i = 1'b0;
      wait_rsp("t1", o);
      check("t1_status", o.st, 0);
      check("t1_rdata", o.rd, 0);
      check("t1_stb_cycles", stb_cnt, 1);

      // 2: read acked after three wait states
      stb_cnt = 0;
      send(1'b0, 32'h20, 16'h5555, 2'b01);
      dat_i = 16'h1234;
      repeat (3) cycle();
      ack_i = 1'b1; cycle(); ack_i = 1'b0; dat_i = '0;
      wait_rsp("t2", o);
      check("t2_status", o.st, 0);
      check("t2_rdata", o.rd, 16'h1234);
      check("t2_stb_cycles", stb_cnt, 4);

      // 3: silent slave
      stb_cnt = 0;
      send(1'b0, 32'h30, 16'h0, 2'b11);
      wait_rsp("t3", o);
      check("t3_status", o.st, 2);
      check("t3_rdata", o.rd, 0);
      check("t3_stb_cycles", stb_cnt, TO);

      // 4: ack and err together, then consumer stalls five cycles
      rsp_ready = 1'b0;
      send(1'b1, 32'h40, 16'hA5A5, 2'b10);
      ack_i = 1'b1; err_i = 1'b1; cycle(); ack_i = 1'b0; err_i = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_valid", rsp_valid, 1);
         check("t4_hold_cmd_ready", cmd_ready, 0);
         check("t4_hold_status", rsp_status, 1);
      end
      cycle(); rsp_ready = 1'b1;
      wait_rsp("t4", o);
      check("t4_status", o.st, 1);
      check("t4_rdata", o.rd, 0);

      // 5: reset while the bus cycle is open, then a late ack
      n0 = obs_q.size();
      send(1'b0, 32'h50, 16'h0, 2'b11);
      repeat (2) cycle();
      rst_i = 1'b1; cycle(); rst_i = 1'b0;
      @(negedge clk);
      check("t5_cyc", cyc_o, 0);
      check("t5_stb", stb_o, 0);
      check("t5_rsp_valid", rsp_valid, 0);
      check("t5_cmd_ready", cmd_ready, 1);
      cycle();
      ack_i = 1'b1; dat_i = 16'hFFFF; cycle(); ack_i = 1'b0; dat_i = '0;
      repeat (5) cycle();
      check("t5_no_rsp", obs_q.size(), n0);

      // 6: back-to-back with ack held high, so idle-time acks are spurious
      ack_i = 1'b1; dat_i = 16'hC3C3;
      for (int i = 0; i < 10; i++)
         send(i[0], 32'h100 + 32'(i * 4), 16'h1000 + 16'(i), 2'b11);
      for (int i = 0; i < 10; i++) begin
         wait_rsp("t6", o);
         check("t6_status", o.st, 0);
         check("t6_rdata", o.rd, i[0] ? 16'h0 : 16'hC3C3);
         if (i > 0) check("t6_spacing_le4", (o.t - prev.t) <= 4, 1);
         prev = o;
      end
      ack_i = 1'b0; dat_i = '0;
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
